sandbox_frame_link: RTL and testbench
=====================================

Name: sandbox_frame_link

Overview:
Host-side end of the sandbox process handshake. It assembles 5-byte command frames (control byte plus 32-bit data word) from a received byte stream and presents them to the sandbox process through dataReceived/control/inputData. It honours the process's clearDR release, and serialises the process's status plus outputData result into a 5-byte response frame whenever transmitData is raised. It sits between the byte-level serial PHY (UART RX/TX) and the sandbox process.

Parameters:
TIMEOUT_CYCLES, 100000, maximum masterClock cycles allowed between bytes of one RX frame before the partial frame is discarded.
TMO_W, 17, width of the inter-byte timeout counter; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
masterClock  in  1  single operating clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
rxValid  in  1  one-cycle strobe; rxByte is valid.
rxByte  in  8  received byte.
txValid  out  1  txByte is valid; held until txReady.
txByte  out  8  byte to transmit.
txReady  in  1  PHY accepts txByte when txValid && txReady.
dataReceived  out  1  a complete command frame is presented.
control  out  8  control byte of the presented frame.
inputData  out  32  data word of the presented frame.
clearDR  in  1  process release; acknowledges the presented frame.
transmitData  in  1  process requests that status/outputData be sent.
status  in  8  process status byte.
outputData  in  32  process result word.
clearErrors  in  1  clears the sticky error flags.
errorFlags  out  3  sticky flags: [0] RX overrun, [1] RX timeout, [2] TX request dropped.

Behaviour:
- Reset (reset=1 at a posedge): every output and internal register goes to 0. This covers dataReceived, control, inputData, txValid, txByte, errorFlags, both FSMs (idle) and all counters. A reset mid-frame discards any partial RX or TX frame without emitting further bytes.
- Frame format, both directions: 5 bytes. Byte 0 is control (RX) or status (TX). Bytes 1-4 are the data word, MSB first (bits [31:24] first).
- RX FSM, R_IDLE/R_COLLECT:
  - R_IDLE: on rxValid, store the byte as shadow control, set byteCnt=1, clear the timeout counter, and go to R_COLLECT.
  - R_COLLECT: each rxValid shifts the byte into the shadow word, increments byteCnt and clears the timeout counter.
  - When the 5th byte is accepted: if dataReceived=0, copy the shadow registers to control/inputData and set dataReceived=1 on the next edge. If dataReceived=1, drop the frame, set errorFlags[0], and leave the presented frame untouched. In both cases return to R_IDLE.
  - Timeout: in R_COLLECT with no rxValid, the counter increments each cycle. At TIMEOUT_CYCLES, discard the partial frame, set errorFlags[1] and go to R_IDLE. An rxValid in the same cycle as the timeout wins: the byte is accepted.
- Process handshake:
  - dataReceived clears on the edge after clearDR is sampled 1; control/inputData keep their values.
  - The process drops clearDR only after seeing dataReceived=0.
  - clearDR=1 while dataReceived=0 has no effect.
  - A new frame completing in the same cycle that clearDR is sampled 1 is treated as overrun. Dropping it is deterministic.
- TX FSM, T_IDLE/T_SEND/T_HOLD:
  - T_IDLE: when transmitData=1, capture status and outputData into the TX shift buffer, set txValid=1 with txByte=status, and go to T_SEND.
  - T_SEND: on txValid&&txReady, advance to the next byte on the following cycle. txValid stays high, so the PHY may accept one byte per cycle. After byte 4 is accepted, drop txValid and go to T_HOLD.
  - T_HOLD: wait for transmitData=0, then go to T_IDLE. One frame is sent per transmitData assertion.
  - txByte and txValid are stable while txValid && !txReady.
  - If transmitData falls and rises again while in T_SEND (a level 0 sampled), set errorFlags[2]. The new request is not queued.
- Latency:
  - RX: last rxValid to dataReceived=1 is 1 cycle.
  - TX: transmitData=1 to txValid=1 is 1 cycle.
- errorFlags:
  - Each flag is sticky. clearErrors=1 clears all three.
  - A set event and a clear in the same cycle resolve with set winning.
- RX and TX paths are independent and run concurrently.

Decomposition:
- Shared package (sandbox_link_pkg): FRAME_BYTES=5, the RX/TX state encodings, and the errorFlags bit indices.
- One natural sub-module, sandbox_frame_tx: the TX FSM, shift buffer and pending-drop detection.
- The RX assembler and the handshake stay in the top.

Test Plan:
- RX bytes 01,DE,AD,BE,EF, clearDR=0 -> after the last byte plus 1 cycle, dataReceived=1, control=8'h01, inputData=32'hDEADBEEF; no errorFlags set.
- Next, clearDR=1 -> dataReceived=0 on the following edge. A second frame 00,00,00,00,2A is then presented with inputData=32'h0000002A.
- With dataReceived=1 held, a full frame 02,11,22,33,44 arrives -> errorFlags=3'b001; control/inputData unchanged (01/DEADBEEF).
- Send 3 bytes, then idle for TIMEOUT_CYCLES -> errorFlags[1]=1 and no dataReceived. A following full frame 03,00,00,00,05 is presented correctly.
- status=8'h03, outputData=32'h12345678, transmitData=1, txReady toggling 1/0 -> txByte sequence 03,12,34,56,78, each byte held until accepted. Only one frame is sent while transmitData stays 1.
- reset=1 in T_SEND after 2 bytes -> txValid=0 the next cycle, all outputs 0, and no further bytes are emitted after reset is released until a new transmitData.

Source files
------------

// File: rtl/sandbox_link_pkg.sv
// sandbox_link_pkg: shared frame constants, FSM encodings and error flag indices for the sandbox link
package sandbox_link_pkg;

   localparam int FRAME_BYTES = 5;

   localparam int ERR_OVERRUN = 0;
   localparam int ERR_TIMEOUT = 1;
   localparam int ERR_TXDROP  = 2;

   typedef enum logic {
      R_IDLE,
      R_COLLECT
   } rxState_t;

   typedef enum logic [1:0] {
      T_IDLE,
      T_SEND,
      T_HOLD
   } txState_t;

endpackage

// File: rtl/sandbox_frame_tx.sv
// sandbox_frame_tx: serialises status + outputData into a 5-byte response frame, one frame per transmitData assertion
module sandbox_frame_tx
   import sandbox_link_pkg::*;
(
   input  logic        masterClock,
   input  logic        reset,
   input  logic        transmitData,
   input  logic [7:0]  status,
   input  logic [31:0] outputData,
   input  logic        txReady,
   output logic        txValid,
   output logic [7:0]  txByte,
   output logic        dropEvent
);

   txState_t    state;
   txState_t    stateNext;
   logic [39:0] shiftBuf;
   logic [2:0]  byteIdx;
   logic        seenLow;
   logic        accept;
   logic        lastByte;

   // The byte on the wire is always the top of the shift buffer; valid only while sending.
   assign txValid = (state == T_SEND);
   assign txByte  = shiftBuf[39:32];

   // Next-state logic; a request that falls and rises again mid-frame is reported, not queued.
   always_comb begin
      stateNext = state;
      accept    = (state == T_SEND) && txReady;
      lastByte  = (byteIdx == 3'(FRAME_BYTES - 1));
      dropEvent = (state == T_SEND) && seenLow && transmitData;
      case (state)
         T_IDLE:  stateNext = transmitData ? T_SEND : T_IDLE;
         T_SEND:  stateNext = (accept && lastByte) ? T_HOLD : T_SEND;
         T_HOLD:  stateNext = transmitData ? T_HOLD : T_IDLE;
         default: stateNext = T_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge masterClock) begin
      if (reset)
         state <= T_IDLE;
      else
         state <= stateNext;
   end

   // Shift buffer, byte index and the "request went low during send" tracker.
   always_ff @(posedge masterClock) begin
      if (reset) begin
         shiftBuf <= '0;
         byteIdx  <= '0;
         seenLow  <= 1'b0;
      end else begin
         if (state == T_IDLE && transmitData) begin
            shiftBuf <= {status, outputData};
            byteIdx  <= '0;
         end else if (accept) begin
            shiftBuf <= {shiftBuf[31:0], 8'h00};
            byteIdx  <= byteIdx + 3'd1;
         end
         seenLow <= (state == T_SEND) && !dropEvent && (seenLow || !transmitData);
      end
   end

endmodule

// File: rtl/sandbox_frame_link.sv
// sandbox_frame_link: host-side sandbox handshake; assembles RX command frames and sends TX response frames
module sandbox_frame_link
   import sandbox_link_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int TMO_W          = 17
) (
   input  logic        masterClock,
   input  logic        reset,
   input  logic        rxValid,
   input  logic [7:0]  rxByte,
   output logic        txValid,
   output logic [7:0]  txByte,
   input  logic        txReady,
   output logic        dataReceived,
   output logic [7:0]  control,
   output logic [31:0] inputData,
   input  logic        clearDR,
   input  logic        transmitData,
   input  logic [7:0]  status,
   input  logic [31:0] outputData,
   input  logic        clearErrors,
   output logic [2:0]  errorFlags
);

   rxState_t         rxState;
   rxState_t         rxNext;
   logic [2:0]       byteCnt;
   logic [7:0]       shadowCtrl;
   logic [23:0]      shadowWord;
   logic [TMO_W-1:0] tmoCnt;
   logic             frameDone;
   logic             timeoutHit;
   logic             txDrop;
   logic [2:0]       errSet;

   // RX next-state: the 5th byte completes a frame; an rxValid beats a coincident timeout.
   always_comb begin
      rxNext     = rxState;
      frameDone  = 1'b0;
      timeoutHit = 1'b0;
      errSet     = '0;
      case (rxState)
         R_IDLE: rxNext = rxValid ? R_COLLECT : R_IDLE;
         R_COLLECT: begin
            if (rxValid) begin
               frameDone = (byteCnt == 3'(FRAME_BYTES - 1));
               rxNext    = frameDone ? R_IDLE : R_COLLECT;
            end else begin
               timeoutHit = (tmoCnt == TMO_W'(TIMEOUT_CYCLES - 1));
               rxNext     = timeoutHit ? R_IDLE : R_COLLECT;
            end
         end
         default: rxNext = R_IDLE;
      endcase
      errSet[ERR_OVERRUN] = frameDone && dataReceived;
      errSet[ERR_TIMEOUT] = timeoutHit;
      errSet[ERR_TXDROP]  = txDrop;
   end

   // RX state register.
   always_ff @(posedge masterClock) begin
      if (reset)
         rxState <= R_IDLE;
      else
         rxState <= rxNext;
   end

   // Shadow frame assembly and inter-byte timeout counter.
   always_ff @(posedge masterClock) begin
      if (reset) begin
         byteCnt    <= '0;
         shadowCtrl <= '0;
         shadowWord <= '0;
         tmoCnt     <= '0;
      end else begin
         if (rxValid) begin
            tmoCnt <= '0;
            if (rxState == R_IDLE) begin
               shadowCtrl <= rxByte;
               shadowWord <= '0;
               byteCnt    <= 3'd1;
            end else begin
               shadowWord <= {shadowWord[15:0], rxByte};
               byteCnt    <= byteCnt + 3'd1;
            end
         end else if (rxState == R_COLLECT) begin
            tmoCnt <= tmoCnt + 1'b1;
         end
         if (frameDone || timeoutHit) begin
            byteCnt <= '0;
            tmoCnt  <= '0;
         end
      end
   end

   // Process handshake: present a completed frame only when the previous one was released.
   always_ff @(posedge masterClock) begin
      if (reset) begin
         dataReceived <= 1'b0;
         control      <= '0;
         inputData    <= '0;
      end else if (frameDone && !dataReceived) begin
         dataReceived <= 1'b1;
         control      <= shadowCtrl;
         inputData    <= {shadowWord, rxByte};
      end else if (clearDR) begin
         dataReceived <= 1'b0;
      end
   end

   // Sticky error flags; a new event wins over a simultaneous clear.
   always_ff @(posedge masterClock) begin
      if (reset)
         errorFlags <= '0;
      else
         errorFlags <= (clearErrors ? 3'b000 : errorFlags) | errSet;
   end

   sandbox_frame_tx txPath (
      .masterClock  (masterClock),
      .reset        (reset),
      .transmitData (transmitData),
      .status       (status),
      .outputData   (outputData),
      .txReady      (txReady),
      .txValid      (txValid),
      .txByte       (txByte),
      .dropEvent    (txDrop)
   );

endmodule

// File: tb/tb_sandbox_frame_link.sv
// tb_sandbox_frame_link: scoreboard bench for the sandbox frame link RX assembly, handshake, timeout and TX paths
module tb_sandbox_frame_link;

   localparam int TMO = 20;

   logic        masterClock = 1'b0;
   logic        reset;
   logic        rxValid;
   logic [7:0]  rxByte;
   logic        txValid;
   logic [7:0]  txByte;
   logic        txReady;
   logic        dataReceived;
   logic [7:0]  control;
   logic [31:0] inputData;
   logic        clearDR;
   logic        transmitData;
   logic [7:0]  status;
   logic [31:0] outputData;
   logic        clearErrors;
   logic [2:0]  errorFlags;

   int total = 0;
   int bad = 0;
   int txPops = 0;
   int base;
   logic [39:0] rxQ[$];
   logic [7:0]  txQ[$];
   logic        drPrev = 1'b0;
   logic        prevValid = 1'b0;
   logic        prevReady = 1'b0;
   logic [7:0]  prevByte = 8'h00;

   sandbox_frame_link #(.TIMEOUT_CYCLES(TMO), .TMO_W(5)) dut (
      .masterClock  (masterClock),
      .reset        (reset),
      .rxValid      (rxValid),
      .rxByte       (rxByte),
      .txValid      (txValid),
      .txByte       (txByte),
      .txReady      (txReady),
      .dataReceived (dataReceived),
      .control      (control),
      .inputData    (inputData),
      .clearDR      (clearDR),
      .transmitData (transmitData),
      .status       (status),
      .outputData   (outputData),
      .clearErrors  (clearErrors),
      .errorFlags   (errorFlags)
   );

   always #5 masterClock = ~masterClock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge masterClock);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] b);
      rxValid = 1'b1;
      rxByte  = b;
      tick();
      rxValid = 1'b0;
   endtask

   task automatic sendFrame(input logic [39:0] f);
      for (int i = 0; i < 5; i++) sendByte(f[39-8*i -: 8]);
   endtask

   task automatic pushTx(input logic [7:0] st, input logic [31:0] d);
      txQ.push_back(st);
      for (int i = 0; i < 4; i++) txQ.push_back(d[31-8*i -: 8]);
   endtask

   // Monitor: compare presented frames and accepted TX bytes against the scoreboard.
   always @(negedge masterClock) begin
      if (reset) begin
         drPrev    = 1'b0;
         prevValid = 1'b0;
         prevReady = 1'b0;
      end else begin
         if (dataReceived && !drPrev) begin
            if (rxQ.size() == 0) check("rxExtra", 64'(rxQ.size()), 64'd1);
            else check("rxFrame", 64'({control, inputData}), 64'(rxQ.pop_front()));
         end
         if (prevValid && !prevReady) begin
            check("txHoldValid", 64'(txValid), 64'd1);
            check("txHoldByte", 64'(txByte), 64'(prevByte));
         end
         if (txValid && txReady) begin
            if (txQ.size() == 0) check("txExtra", 64'(txQ.size()), 64'd1);
            else begin
               check("txByte", 64'(txByte), 64'(txQ.pop_front()));
               txPops++;
            end
         end
         drPrev    = dataReceived;
         prevValid = txValid;
         prevReady = txReady;
         prevByte  = txByte;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; rxValid = 1'b0; rxByte = 8'h00; txReady = 1'b0; clearDR = 1'b0;
      transmitData = 1'b0; status = 8'h00; outputData = 32'h0; clearErrors = 1'b0;
      repeat (3) tick();
      check("rstRx", 64'({dataReceived, control, inputData}), 64'd0);
      check("rstTx", 64'({txValid, txByte}), 64'd0);
      check("rstErr", 64'(errorFlags), 64'd0);
      reset = 1'b0;
      tick();

      rxQ.push_back(40'h01DEADBEEF);
      sendFrame(40'h01DEADBEEF);
      check("rxLatency", 64'(dataReceived), 64'd1);
      check("errNone", 64'(errorFlags), 64'd0);
      tick();

      sendFrame(40'h0211223344);
      check("overrunFlag", 64'(errorFlags), 64'b001);
      check("overrunKeep", 64'({control, inputData}), 64'h01DEADBEEF);
      check("overrunDR", 64'(dataReceived), 64'd1);
      clearErrors = 1'b1; tick(); clearErrors = 1'b0;
      check("clrErr", 64'(errorFlags), 64'd0);

      clearDR = 1'b1; tick();
      check("clearDR", 64'(dataReceived), 64'd0);
      check("clearKeep", 64'({control, inputData}), 64'h01DEADBEEF);
      tick();
      check("clearIdle", 64'(dataReceived), 64'd0);
      clearDR = 1'b0;

      rxQ.push_back(40'h000000002A);
      sendFrame(40'h000000002A);
      check("frame2DR", 64'(dataReceived), 64'd1);
      tick();

      sendByte(8'h05); sendByte(8'h99); sendByte(8'h88); sendByte(8'h77);
      clearDR = 1'b1; clearErrors = 1'b1;
      sendByte(8'h66);
      clearDR = 1'b0; clearErrors = 1'b0;
      check("coincDR", 64'(dataReceived), 64'd0);
      check("coincErr", 64'(errorFlags), 64'b001);
      check("coincKeep", 64'({control, inputData}), 64'h000000002A);
      clearErrors = 1'b1; tick(); clearErrors = 1'b0;

      sendByte(8'h07); sendByte(8'h08); sendByte(8'h09);
      repeat (TMO - 1) tick();
      check("tmoEarly", 64'(errorFlags), 64'd0);
      tick();
      check("tmoFlag", 64'(errorFlags), 64'b010);
      check("tmoNoDR", 64'(dataReceived), 64'd0);
      rxQ.push_back(40'h0300000005);
      sendFrame(40'h0300000005);
      check("tmoNextDR", 64'(dataReceived), 64'd1);
      clearDR = 1'b1; clearErrors = 1'b1; tick(); clearDR = 1'b0; clearErrors = 1'b0;

      rxQ.push_back(40'h04A1B2C3D4);
      sendByte(8'h04); sendByte(8'hA1);
      repeat (TMO - 1) tick();
      sendByte(8'hB2); sendByte(8'hC3); sendByte(8'hD4);
      check("tmoRaceErr", 64'(errorFlags), 64'd0);
      check("tmoRaceDR", 64'(dataReceived), 64'd1);
      clearDR = 1'b1; tick(); clearDR = 1'b0;

      status = 8'h03; outputData = 32'h12345678; txReady = 1'b0;
      pushTx(8'h03, 32'h12345678);
      transmitData = 1'b1;
      tick();
      check("txLatency", 64'({txValid, txByte}), 64'h103);
      for (int i = 0; i < 40 && txQ.size() != 0; i++) begin
         txReady = 1'(i % 2);
         tick();
      end
      check("txDrain", 64'(txQ.size()), 64'd0);
      txReady = 1'b1;
      repeat (10) tick();
      check("txOneFrame", 64'(txValid), 64'd0);
      check("txNoDrop", 64'(errorFlags), 64'd0);
      transmitData = 1'b0; tick();

      status = 8'hAA; outputData = 32'h01020304; txReady = 1'b0;
      pushTx(8'hAA, 32'h01020304);
      transmitData = 1'b1; tick();
      transmitData = 1'b0; tick();
      transmitData = 1'b1; tick();
      check("txDropFlag", 64'(errorFlags), 64'b100);
      txReady = 1'b1;
      for (int i = 0; i < 20 && txQ.size() != 0; i++) tick();
      check("txDropDrain", 64'(txQ.size()), 64'd0);
      repeat (5) tick();
      check("txDropHold", 64'(txValid), 64'd0);
      transmitData = 1'b0; clearErrors = 1'b1; tick(); clearErrors = 1'b0;

      rxQ.push_back(40'h0900000001);
      sendFrame(40'h0900000001);
      status = 8'h03; outputData = 32'h12345678;
      pushTx(8'h03, 32'h12345678);
      txReady = 1'b1; transmitData = 1'b1;
      base = txPops;
      for (int i = 0; i < 20 && txPops - base < 2; i++) tick();
      check("txTwoBytes", 64'(txPops - base), 64'd2);
      txReady = 1'b0; reset = 1'b1; transmitData = 1'b0;
      txQ.delete();
      tick();
      check("midRstTx", 64'({txValid, txByte}), 64'd0);
      check("midRstRx", 64'({dataReceived, control, inputData}), 64'd0);
      check("midRstErr", 64'(errorFlags), 64'd0);
      reset = 1'b0; txReady = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("postRstValid", 64'(txValid), 64'd0);
      end

      check("rxQEnd", 64'(rxQ.size()), 64'd0);
      check("txQEnd", 64'(txQ.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
